// File: rtl/vend_payout_sequencer.sv
// vend_payout_sequencer: runs the physical half of one accepted vend. It pulses the spiral
// motor, confirms the drop, then pays change one coin per hopper handshake, largest coin first.
// All outputs are registered. Each one is decoded from the next state or from the next-state
// datapath values.
module vend_payout_sequencer #(
  parameter int unsigned MOTOR_CYCLES   = 8,
  parameter int unsigned SENSE_TIMEOUT  = 64,
  parameter int unsigned HOPPER_TIMEOUT = 64
) (
  input  logic        I_CLK,
  input  logic        I_RESET_N,
  input  logic        I_VEND_VALID,
  output logic        O_VEND_READY,
  input  logic [3:0]  I_VEND_SEL,
  input  logic [15:0] I_VEND_CHANGE,
  output logic        O_MOTOR_EN,
  output logic [3:0]  O_MOTOR_SEL,
  input  logic        I_ITEM_SENSE,
  output logic        O_COIN_REQ,
  output logic [2:0]  O_COIN_TYPE,
  input  logic        I_COIN_ACK,
  output logic [15:0] O_REMAIN,
  output logic        O_DONE,
  output logic [1:0]  O_FAULT
);

  // Terminal counts. Each count is compared on the last cycle of its window.
  localparam logic [7:0] MotorLast  = 8'(MOTOR_CYCLES - 1);
  localparam logic [7:0] SenseLast  = 8'(SENSE_TIMEOUT - 1);
  localparam logic [7:0] HopperLast = 8'(HOPPER_TIMEOUT - 1);

  localparam logic [2:0] Coin100 = 3'd0;
  localparam logic [2:0] Coin25  = 3'd1;
  localparam logic [2:0] Coin10  = 3'd2;
  localparam logic [2:0] Coin5   = 3'd3;
  localparam logic [2:0] Coin1   = 3'd4;

  localparam logic [1:0] FaultNone   = 2'b00;
  localparam logic [1:0] FaultNoItem = 2'b01;
  localparam logic [1:0] FaultHopper = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StMotor,
    StSenseWait,
    StPayout,
    StCoinWait,
    StDone,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        item_seen_q, item_seen_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] remain_q, remain_d;
  logic [2:0]  coin_type_q, coin_type_d;
  logic [1:0]  fault_q, fault_d;
  logic        ready_q, ready_d;
  logic        motor_en_q, motor_en_d;
  logic        coin_req_q, coin_req_d;
  logic        done_q, done_d;
  logic        vend_xfer;

  // Value in cents of each coin code.
  function automatic logic [15:0] coin_value(input logic [2:0] coin_type);
    logic [15:0] value;
    case (coin_type)
      Coin100: value = 16'd100;
      Coin25:  value = 16'd25;
      Coin10:  value = 16'd10;
      Coin5:   value = 16'd5;
      default: value = 16'd1;
    endcase
    return value;
  endfunction

  // Largest coin not exceeding the amount owed. Because of this choice, the later
  // subtraction can never underflow.
  function automatic logic [2:0] pick_coin(input logic [15:0] amount);
    logic [2:0] coin;
    if (amount >= 16'd100) begin
      coin = Coin100;
    end else if (amount >= 16'd25) begin
      coin = Coin25;
    end else if (amount >= 16'd10) begin
      coin = Coin10;
    end else if (amount >= 16'd5) begin
      coin = Coin5;
    end else begin
      coin = Coin1;
    end
    return coin;
  endfunction

  // A request is only taken in IDLE, where the registered ready is high.
  assign vend_xfer = (state_q == StIdle) && I_VEND_VALID && ready_q;

  // State register.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (vend_xfer) state_d = StMotor;
      end
      StMotor: begin
        if (cnt_q == MotorLast) state_d = StSenseWait;
      end
      StSenseWait: begin
        // A pulse on the final wait cycle still counts as a drop.
        if (item_seen_q || I_ITEM_SENSE) begin
          state_d = StPayout;
        end else if (cnt_q == SenseLast) begin
          state_d = StFault;
        end
      end
      StPayout: begin
        state_d = (remain_q == 16'd0) ? StDone : StCoinWait;
      end
      StCoinWait: begin
        if (I_COIN_ACK) begin
          state_d = StPayout;
        end else if (cnt_q == HopperLast) begin
          state_d = StFault;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath next values: timeout counter, drop flag, latched slot, change owed, coin, fault.
  always_comb begin
    cnt_d       = cnt_q;
    item_seen_d = item_seen_q;
    sel_d       = sel_q;
    remain_d    = remain_q;
    coin_type_d = coin_type_q;
    fault_d     = fault_q;

    // The counter restarts on every state entry and only runs in the timed states.
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if ((state_q == StMotor) || (state_q == StSenseWait) ||
                 (state_q == StCoinWait)) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (vend_xfer) begin
      sel_d       = I_VEND_SEL;
      remain_d    = I_VEND_CHANGE;
      item_seen_d = 1'b0;
    end

    if (((state_q == StMotor) || (state_q == StSenseWait)) && I_ITEM_SENSE) begin
      item_seen_d = 1'b1;
    end

    if ((state_q == StPayout) && (remain_q != 16'd0)) begin
      coin_type_d = pick_coin(remain_q);
    end

    if ((state_q == StCoinWait) && I_COIN_ACK) begin
      remain_d = remain_q - coin_value(coin_type_q);
    end

    if ((state_q == StSenseWait) && (state_d == StFault)) begin
      fault_d = FaultNoItem;
    end else if ((state_q == StCoinWait) && (state_d == StFault)) begin
      fault_d = FaultHopper;
    end
  end

  // Output decode from the next state, so every output flop matches the state it enters.
  always_comb begin
    ready_d    = (state_d == StIdle);
    motor_en_d = (state_d == StMotor);
    coin_req_d = (state_d == StCoinWait);
    done_d     = (state_d == StDone);
  end

  // Datapath and output registers.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      cnt_q       <= 8'd0;
      item_seen_q <= 1'b0;
      sel_q       <= 4'd0;
      remain_q    <= 16'd0;
      coin_type_q <= Coin100;
      fault_q     <= FaultNone;
      ready_q     <= 1'b1;
      motor_en_q  <= 1'b0;
      coin_req_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      item_seen_q <= item_seen_d;
      sel_q       <= sel_d;
      remain_q    <= remain_d;
      coin_type_q <= coin_type_d;
      fault_q     <= fault_d;
      ready_q     <= ready_d;
      motor_en_q  <= motor_en_d;
      coin_req_q  <= coin_req_d;
      done_q      <= done_d;
    end
  end

  assign O_VEND_READY = ready_q;
  assign O_MOTOR_EN   = motor_en_q;
  assign O_MOTOR_SEL  = sel_q;
  assign O_COIN_REQ   = coin_req_q;
  assign O_COIN_TYPE  = coin_type_q;
  assign O_REMAIN     = remain_q;
  assign O_DONE       = done_q;
  assign O_FAULT      = fault_q;

endmodule

// File: tb/tb_vend_payout_sequencer.sv
// Bench for vend_payout_sequencer: directed vector table, reset/abort sequence, then random
// transactions checked against a transaction-level model (greedy change list, fault rules).
module tb_vend_payout_sequencer;

  localparam int MotorCycles   = 8;
  localparam int SenseTimeout  = 64;
  localparam int HopperTimeout = 64;
  localparam int Budget        = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vend_valid;
  logic        vend_ready;
  logic [3:0]  vend_sel;
  logic [15:0] vend_change;
  logic        motor_en;
  logic [3:0]  motor_sel;
  logic        item_sense;
  logic        coin_req;
  logic [2:0]  coin_type;
  logic        coin_ack;
  logic [15:0] remain;
  logic        done;
  logic [1:0]  fault;

  always #5 clk = ~clk;

  vend_payout_sequencer #(
    .MOTOR_CYCLES  (MotorCycles),
    .SENSE_TIMEOUT (SenseTimeout),
    .HOPPER_TIMEOUT(HopperTimeout)
  ) dut (
    .I_CLK        (clk),
    .I_RESET_N    (rst_n),
    .I_VEND_VALID (vend_valid),
    .O_VEND_READY (vend_ready),
    .I_VEND_SEL   (vend_sel),
    .I_VEND_CHANGE(vend_change),
    .O_MOTOR_EN   (motor_en),
    .O_MOTOR_SEL  (motor_sel),
    .I_ITEM_SENSE (item_sense),
    .O_COIN_REQ   (coin_req),
    .O_COIN_TYPE  (coin_type),
    .I_COIN_ACK   (coin_ack),
    .O_REMAIN     (remain),
    .O_DONE       (done),
    .O_FAULT      (fault)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] change;
    int          sense_at;   // cycle index after transfer of the drop pulse, -1 = never
    int          ack_delay;  // REQ-high cycles before the hopper acks
    int          ack_limit;  // coins the hopper will ever ack
    bit          stray;      // toggle VALID, stray ACK/SENSE while busy
    logic [1:0]  exp_fault;
    int          exp_ncoins;
    logic [23:0] exp_types;  // coin i at bits [3i+:3]
    logic [15:0] exp_remain;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int coin_cents(input int t);
    int den[5] = '{100, 25, 10, 5, 1};
    return den[t];
  endfunction

  function automatic int largest_coin(input int amt);
    for (int i = 0; i < 5; i++) begin
      if (coin_cents(i) <= amt) return i;
    end
    return 4;
  endfunction

  function automatic vec_t mk(input logic [3:0] sel, input logic [15:0] change, input int sense_at,
                              input int ack_delay, input int ack_limit, input bit stray,
                              input logic [1:0] exp_fault, input int exp_ncoins,
                              input logic [23:0] exp_types, input logic [15:0] exp_remain);
    vec_t v;
    v.sel = sel; v.change = change; v.sense_at = sense_at; v.ack_delay = ack_delay;
    v.ack_limit = ack_limit; v.stray = stray; v.exp_fault = exp_fault;
    v.exp_ncoins = exp_ncoins; v.exp_types = exp_types; v.exp_remain = exp_remain;
    return v;
  endfunction

  // Transaction-level model: greedy coin list, truncated by the hopper's ack limit.
  task automatic build_model(inout vec_t v);
    int g[$];
    int amt;
    int paid;
    amt  = int'(v.change);
    paid = 0;
    exp_q.delete();
    while (amt > 0) begin
      g.push_back(largest_coin(amt));
      amt -= coin_cents(largest_coin(amt));
    end
    if (v.sense_at < 0) begin
      v.exp_fault  = 2'b01;
      v.exp_remain = v.change;
    end else if (v.ack_limit >= g.size()) begin
      exp_q        = g;
      v.exp_fault  = 2'b00;
      v.exp_remain = 16'd0;
    end else begin
      for (int i = 0; i <= v.ack_limit; i++) exp_q.push_back(g[i]);
      for (int i = 0; i < v.ack_limit; i++) paid += coin_cents(g[i]);
      v.exp_fault  = 2'b10;
      v.exp_remain = 16'(int'(v.change) - paid);
    end
    v.exp_ncoins = exp_q.size();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vend_valid = 1'b0; item_sense = 1'b0; coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one transaction from IDLE and acts as the hopper. Sampling is on the negedge.
  task automatic run_txn(input vec_t v, input bit from_model);
    int idx, motor_cnt, sel_bad, busy_ready, drop_bad, stable_bad, done_cnt;
    int req_run, last_run, acks, fault_idx, rem, cur_type, held_bad;
    bit fin, ack, ack_prev, first_motor;
    logic [15:0] fin_remain;
    logic [1:0]  fin_fault;
    if (!from_model) begin
      exp_q.delete();
      for (int i = 0; i < v.exp_ncoins; i++) exp_q.push_back(int'(v.exp_types[3*i +: 3]));
    end
    obs_q.delete();
    idx = 0; motor_cnt = 0; sel_bad = 0; busy_ready = 0; drop_bad = 0; stable_bad = 0;
    done_cnt = 0; req_run = 0; last_run = 0; acks = 0; fault_idx = -1; held_bad = 0;
    rem = int'(v.change); cur_type = 0; fin = 1'b0; ack_prev = 1'b0;
    fin_remain = 16'd0; fin_fault = 2'b00;

    @(negedge clk);
    vend_sel = v.sel; vend_change = v.change; vend_valid = 1'b1;
    @(negedge clk);
    if (!v.stray) vend_valid = 1'b0;
    first_motor = motor_en;

    while (!fin && idx < Budget) begin
      if (motor_en) begin
        motor_cnt++;
        if (motor_sel !== v.sel) sel_bad++;
      end
      if (vend_ready) busy_ready++;
      if (ack_prev && coin_req) drop_bad++;
      if (coin_req) begin
        if (req_run == 0) begin
          obs_q.push_back(int'(coin_type));
          cur_type = int'(coin_type);
          check("remain_at_req", 32'(remain), 32'(rem));
        end else if (int'(coin_type) != cur_type || int'(remain) != rem) begin
          stable_bad++;
        end
        req_run++;
      end else if (req_run != 0) begin
        last_run = req_run;
        req_run  = 0;
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
      if (fault != 2'b00) begin
        fault_idx = idx;
        fin = 1'b1;
      end
      fin_remain = remain;
      fin_fault  = fault;

      // Drive inputs for the coming edge.
      item_sense = (idx == v.sense_at) ? 1'b1 : 1'b0;
      ack = 1'b0;
      if (coin_req && (req_run - 1 == v.ack_delay) && (acks < v.ack_limit)) begin
        ack = 1'b1;
        if (acks < exp_q.size()) rem -= coin_cents(exp_q[acks]);
        acks++;
      end
      if (v.stray) begin
        if (motor_en && idx >= 1 && idx <= 3) ack = 1'b1;
        if (!coin_req && obs_q.size() > 0) begin
          ack        = 1'($urandom);
          item_sense = 1'b1;
        end
        vend_valid  = done ? 1'b0 : 1'($urandom);
        vend_sel    = 4'($urandom);
        vend_change = 16'($urandom);
      end
      coin_ack = ack;
      ack_prev = ack && coin_req;
      if (!fin) begin
        @(negedge clk);
        idx++;
      end
    end

    check("txn_finished", 32'(fin), 32'd1);
    vend_valid = 1'b0; item_sense = 1'b0; coin_ack = 1'b0;
    check("motor_start", 32'(first_motor), 32'd1);
    check("motor_cycles", 32'(motor_cnt), 32'(MotorCycles));
    check("motor_sel", 32'(sel_bad), 32'd0);
    check("ready_while_busy", 32'(busy_ready), 32'd0);
    check("req_drop_after_ack", 32'(drop_bad), 32'd0);
    check("req_type_stable", 32'(stable_bad), 32'd0);
    check("coin_count", 32'(obs_q.size()), 32'(v.exp_ncoins));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("coin_type", 32'(obs_q[i]), 32'(exp_q[i]));
    end
    check("fault_code", 32'(fin_fault), 32'(v.exp_fault));
    check("final_remain", 32'(fin_remain), 32'(v.exp_remain));
    check("done_pulses", 32'(done_cnt), (v.exp_fault == 2'b00) ? 32'd1 : 32'd0);
    if (v.exp_fault == 2'b01) begin
      check("sense_timeout_at", 32'(fault_idx), 32'(MotorCycles + SenseTimeout));
    end
    if (v.exp_fault == 2'b10) begin
      check("hopper_timeout_len", 32'(last_run), 32'(HopperTimeout));
    end

    if (v.exp_fault == 2'b00) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("ready_after_done", 32'(vend_ready), 32'd1);
      @(negedge clk);
      check("no_second_txn", 32'(motor_en), 32'd0);
    end else begin
      // FAULT is terminal: requests are refused and the fault and remainder hold.
      vend_valid = 1'b1;
      coin_ack   = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (vend_ready || motor_en || coin_req || fault !== v.exp_fault ||
            remain !== v.exp_remain) held_bad++;
      end
      vend_valid = 1'b0;
      coin_ack   = 1'b0;
      check("fault_terminal", 32'(held_bad), 32'd0);
      do_reset();
    end
  endtask

  vec_t vecs[7];
  vec_t rv;
  int   wait_i;

  initial begin
    rst_n = 1'b0;
    vend_valid = 1'b0; vend_sel = 4'd0; vend_change = 16'd0;
    item_sense = 1'b0; coin_ack = 1'b0;

    vecs[0] = mk(4'd5, 16'd0, 2, 2, 100, 1'b0, 2'b00, 0, 24'd0, 16'd0);
    vecs[1] = mk(4'd15, 16'd190, 0, 2, 100, 1'b0, 2'b00, 6,
                 {3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0}, 16'd0);
    vecs[2] = mk(4'd0, 16'd100, -1, 2, 100, 1'b0, 2'b01, 0, 24'd0, 16'd100);
    vecs[3] = mk(4'd9, 16'd41, 4, 1, 2, 1'b0, 2'b10, 3, {15'd0, 3'd3, 3'd2, 3'd1}, 16'd6);
    vecs[4] = mk(4'd6, 16'd68, 40, 0, 100, 1'b0, 2'b00, 7,
                 {3'd0, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1}, 16'd0);
    vecs[5] = mk(4'd12, 16'd35, 5, 3, 100, 1'b1, 2'b00, 2, {18'd0, 3'd2, 3'd1}, 16'd0);
    vecs[6] = mk(4'd7, 16'd4, 7, 0, 0, 1'b0, 2'b10, 1, {21'd0, 3'd4}, 16'd4);

    // Reset state, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(vend_ready), 32'd1);
    check("rst_motor_en", 32'(motor_en), 32'd0);
    check("rst_coin_req", 32'(coin_req), 32'd0);
    check("rst_remain", 32'(remain), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i], 1'b0);

    // Asynchronous reset in the middle of COIN_WAIT.
    @(negedge clk);
    vend_sel = 4'd2; vend_change = 16'd41; vend_valid = 1'b1;
    @(negedge clk);
    vend_valid = 1'b0;
    item_sense = 1'b1;
    wait_i = 0;
    while (!coin_req && wait_i < 200) begin
      @(negedge clk);
      item_sense = 1'b0;
      wait_i++;
    end
    item_sense = 1'b0;
    check("abort_reached_coin_wait", 32'(coin_req), 32'd1);
    #2 rst_n = 1'b0;
    vend_valid = 1'b1;
    #1;
    check("abort_ready", 32'(vend_ready), 32'd1);
    check("abort_motor_en", 32'(motor_en), 32'd0);
    check("abort_motor_sel", 32'(motor_sel), 32'd0);
    check("abort_coin_req", 32'(coin_req), 32'd0);
    check("abort_coin_type", 32'(coin_type), 32'd0);
    check("abort_remain", 32'(remain), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fault", 32'(fault), 32'd0);
    repeat (2) @(negedge clk);
    check("no_xfer_in_reset", 32'(motor_en), 32'd0);
    vend_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", 32'(motor_en), 32'd0);
    run_txn(mk(4'd3, 16'd1, 1, 1, 100, 1'b0, 2'b00, 1, {21'd0, 3'd4}, 16'd0), 1'b0);

    // Random transactions against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      rv.sel       = 4'($urandom);
      rv.change    = 16'($urandom_range(0, 400));
      rv.sense_at  = ($urandom_range(0, 99) < 15) ? -1 : int'($urandom_range(0, 70));
      rv.ack_delay = int'($urandom_range(0, 5));
      rv.ack_limit = ($urandom_range(0, 99) < 80) ? 100 : int'($urandom_range(0, 3));
      rv.stray     = ($urandom_range(0, 3) == 0);
      rv.exp_types = 24'd0;
      build_model(rv);
      run_txn(rv, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
